sprite_blitter: RTL and testbench

Copies one sprite image from an image ROM (RGB565, row-major, address 0 = top-left pixel, one-cycle registered read) into the VGA frame-buffer write port at a given destination. It is the read-side initiator of the image-ROM interface and the write-side initiator of the frame buffer. It sits between the game-logic controller (start/done handshake) and the frame-buffer RAM.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/sprite_blitter_if.sv | 30 +++
 rtl/sprite_blitter_fb_addr_gen.sv | 24 ++
 rtl/sprite_blitter.sv | 127 ++++++++++++
 tb/tb_sprite_blitter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA/blitter types and defaults.
//   FB_W_DEF / FB_H_DEF : frame-buffer geometry (320x240)
//   KEY_COLOR_DEF       : RGB565 transparency key (magenta)
//   rgb565_t            : one RGB565 pixel
//   blit_state_t        : blitter FSM states
//   blit_req_t          : latched blit request (destination + size)
package vga_pkg;
  localparam int          FB_W_DEF      = 320;
  localparam int          FB_H_DEF      = 240;
  localparam logic [15:0] KEY_COLOR_DEF = 16'hF81F;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} blit_state_t;

  typedef struct packed {
    logic [9:0] dst_x;
    logic [8:0] dst_y;
    logic [7:0] spr_w;
    logic [7:0] spr_h;
  } blit_req_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: bundles the blitter's control handshake, image-ROM read
// port and frame-buffer write port.
//   master : the blitter (drives busy/done, rom_addr, fb_we/fb_addr/fb_wdata)
//   slave  : the environment (controller, ROM, frame buffer)
interface sprite_blitter_if;
  import vga_pkg::*;

  logic        start;
  logic [9:0]  dst_x;
  logic [8:0]  dst_y;
  logic [7:0]  spr_w;
  logic [7:0]  spr_h;
  logic        busy;
  logic        done;
  logic [16:0] rom_addr;
  rgb565_t     rom_data;
  logic        fb_we;
  logic [16:0] fb_addr;
  rgb565_t     fb_wdata;

  modport master (
    input  start, dst_x, dst_y, spr_w, spr_h, rom_data,
    output busy, done, rom_addr, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    output start, dst_x, dst_y, spr_w, spr_h, rom_data,
    input  busy, done, rom_addr, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/sprite_blitter_fb_addr_gen.sv
// fb_addr_gen: combinational frame-buffer address, addr = y*FB_W + x.
//   y    : row (10 bits, may exceed screen; result is then meaningless)
//   x    : column (11 bits)
//   addr : 17-bit linear address
// For FB_W=320 the multiply is two shifts and an add (256+64).
module fb_addr_gen #(
  parameter int FB_W = 320
) (
  input  logic [9:0]  y,
  input  logic [10:0] x,
  output logic [16:0] addr
);
  logic [16:0] row_base;

  generate
    if (FB_W == 320) begin : g_shift
      assign row_base = ({7'd0, y} << 8) + ({7'd0, y} << 6);
    end else begin : g_mul
      assign row_base = {7'd0, y} * 17'(FB_W);
    end
  endgenerate

  assign addr = row_base + {6'd0, x};
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a spr_w x spr_h RGB565 sprite from an image ROM
// (one-cycle registered read) into the frame buffer at (dst_x, dst_y),
// one pixel per clock, clipping pixels that fall off-screen.
//   clk, reset_n : clock, async active-low reset
//   bus (master) : start/dst/spr in, busy/done out; rom_addr out, rom_data in;
//                  fb_we/fb_addr/fb_wdata out
// Optional feature macro SPRITE_BLITTER_TRANSPARENCY_EN: pixels equal to
// KEY_COLOR are not written.
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  ,
  parameter rgb565_t KEY_COLOR = KEY_COLOR_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  sprite_blitter_if.master bus
);
  localparam logic [10:0] FB_W_L = 11'(FB_W);
  localparam logic [9:0]  FB_H_L = 10'(FB_H);

  blit_state_t state;
  blit_req_t   req;
  logic [7:0]  col, row;
  logic [16:0] rom_addr_q;
  logic        busy_q, done_q;

  // write stage: one cycle behind the read issue, aligned with rom_data
  logic        wr_vld, wr_on;
  logic [16:0] fb_addr_q;

  logic [10:0] px;
  logic [9:0]  py;
  logic        on_scr, last, key_ok;
  logic [16:0] pix_addr;

  // sums are wide enough never to wrap, so clipping is a plain compare
  assign px     = {1'b0, req.dst_x} + {3'd0, col};
  assign py     = {1'b0, req.dst_y} + {2'd0, row};
  assign on_scr = (px < FB_W_L) && (py < FB_H_L);
  assign last   = (col == req.spr_w - 8'd1) && (row == req.spr_h - 8'd1);

  fb_addr_gen #(.FB_W(FB_W)) u_addr (
    .y    (py),
    .x    (px),
    .addr (pix_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req        <= '0;
      col        <= '0;
      row        <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_vld     <= 1'b0;
      wr_on      <= 1'b0;
      fb_addr_q  <= '0;
    end else begin
      wr_vld <= (state == READ);
      wr_on  <= on_scr;
      if (state == READ) fb_addr_q <= pix_addr;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            req        <= '{dst_x: bus.dst_x, dst_y: bus.dst_y,
                            spr_w: bus.spr_w, spr_h: bus.spr_h};
            col        <= '0;
            row        <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
            // empty sprite: skip straight to the done pulse
            if (bus.spr_w == 8'd0 || bus.spr_h == 8'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (last) begin
            state <= DRAIN;
          end else begin
            rom_addr_q <= rom_addr_q + 17'd1;
            if (col == req.spr_w - 8'd1) begin
              col <= '0;
              row <= row + 8'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        DRAIN: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign key_ok = (bus.rom_data != KEY_COLOR);
`else
  assign key_ok = 1'b1;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.fb_we    = wr_vld & wr_on & key_ok;
  assign bus.fb_addr  = fb_addr_q;
  // gated so the data port reads 0 out of reset regardless of ROM contents
  assign bus.fb_wdata = wr_vld ? bus.rom_data : '0;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized self-checking bench for sprite_blitter.
// A per-blit model lists, for every cycle after start, whether a write is
// expected and with which address/data, computed from pixel index
// arithmetic; the DUT is compared cycle by cycle.
module tb_sprite_blitter;
  import vga_pkg::*;

  localparam int SW = 320;
  localparam int SH = 240;
  localparam logic [15:0] KEY = 16'hF81F;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_blitter_if bus();

  sprite_blitter u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // registered-read image ROM
  logic [15:0] mem [0:131071];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill(input int wh, input int key_pct);
    for (int k = 0; k < wh; k++) begin
      mem[k] = 16'($urandom);
      if (int'($urandom_range(99)) < key_pct) mem[k] = KEY;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_we"},    32'(bus.fb_we), 0);
    chk({tag, "_raddr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_faddr"}, 32'(bus.fb_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.fb_wdata), 0);
  endtask

  // Runs one blit. restart_c: cycle (after start edge) in which start is
  // raised again (0 = never). rst_c: cycle in which reset is pulsed (0 = never).
  task automatic blit(input int dx, input int dy, input int w, input int h,
                      input int restart_c, input int rst_c, output int nwr);
    int wh, done_c, last_c, nexp;
    bit exp_we[];
    int exp_addr[];
    int exp_data[];
    bit aborted;
    wh     = w * h;
    done_c = (wh == 0) ? 1 : wh + 2;
    last_c = done_c + 1;
    exp_we   = new[last_c + 1];
    exp_addr = new[last_c + 1];
    exp_data = new[last_c + 1];
    for (int c = 0; c <= last_c; c++) begin
      exp_we[c] = 1'b0; exp_addr[c] = 0; exp_data[c] = 0;
    end
    nexp = 0;
    // pixel k is row k/w, column k%w; written two cycles after start
    for (int k = 0; k < wh; k++) begin
      int x;
      int y;
      bit pass;
      x = dx + k % w;
      y = dy + k / w;
      pass = 1'b1;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
      if (mem[k] == KEY) pass = 1'b0;
`endif
      if (x < SW && y < SH && pass) begin
        exp_we[k + 2]   = 1'b1;
        exp_addr[k + 2] = y * SW + x;
        exp_data[k + 2] = int'(mem[k]);
        nexp++;
      end
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.dst_x = 10'(dx);
    bus.dst_y = 9'(dy);
    bus.spr_w = 8'(w);
    bus.spr_h = 8'(h);
    @(posedge clk);
    nwr = 0;
    aborted = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == rst_c) begin
        reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("post_rst_done", 32'(bus.done), 0);
          chk("post_rst_busy", 32'(bus.busy), 0);
          chk("post_rst_we",   32'(bus.fb_we), 0);
        end
        aborted = 1'b1;
        break;
      end
      chk("busy", 32'(bus.busy), 32'(c <= done_c));
      chk("done", 32'(bus.done), 32'(c == done_c));
      chk("we",   32'(bus.fb_we), 32'(exp_we[c]));
      if (exp_we[c]) begin
        chk("fb_addr",  32'(bus.fb_addr), 32'(exp_addr[c]));
        chk("fb_wdata", 32'(bus.fb_wdata), 32'(exp_data[c]));
      end
      if (bus.fb_we) begin
        nwr++;
        chk("addr_range", 32'(bus.fb_addr < 17'd76800), 1);
      end
      if (c <= wh) chk("rom_addr", 32'(bus.rom_addr), 32'(c - 1));
      if (wh == 0 && c == 1) chk("rom_addr0", 32'(bus.rom_addr), 0);
      // inputs wander while busy; only the latched request may matter
      bus.start = (c == restart_c);
      bus.dst_x = 10'($urandom);
      bus.dst_y = 9'($urandom);
      bus.spr_w = 8'($urandom);
      bus.spr_h = 8'($urandom);
    end
    bus.start = 1'b0;
    if (!aborted) chk("n_writes", 32'(nwr), 32'(nexp));
  endtask

  initial begin
    int nwr;
    bus.start = 1'b0;
    bus.dst_x = '0;
    bus.dst_y = '0;
    bus.spr_w = '0;
    bus.spr_h = '0;
    for (int k = 0; k < 131072; k++) mem[k] = 16'h0;

    #1;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_zero("idle");

    // directed 2x2 at (10,5): addresses 1610,1611,1930,1931
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    blit(10, 5, 2, 2, 0, 0, nwr);
    chk("2x2_writes", 32'(nwr), 4);

    // clipped 50x50 at bottom-right corner: 20x20 visible
    fill(2500, 0);
    blit(300, 220, 50, 50, 0, 0, nwr);
    chk("clip_writes", 32'(nwr), 400);

    // transparency key on pixel 1
    mem[0] = 16'h1111; mem[1] = KEY; mem[2] = 16'h3333; mem[3] = 16'h4444;
    blit(10, 5, 2, 2, 0, 0, nwr);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("key_writes", 32'(nwr), 3);
`else
    chk("key_writes", 32'(nwr), 4);
`endif

    // empty sprites
    blit(20, 20, 0, 5, 0, 0, nwr);
    blit(20, 20, 7, 0, 0, 0, nwr);

    // start pulsed again mid-blit
    fill(4, 0);
    blit(100, 50, 2, 2, 3, 0, nwr);
    chk("restart_writes", 32'(nwr), 4);

    // reset in cycle 3 of a 50x50, then a fresh full blit
    fill(2500, 5);
    blit(40, 30, 50, 50, 0, 3, nwr);
    blit(40, 30, 50, 50, 0, 0, nwr);
    chk("fresh_writes", 32'(nwr), 2500 - (2500 - nwr));

    // randomized blits, some near or past the screen edges
    for (int t = 0; t < 24; t++) begin
      int w, h, dx, dy, rs;
      w  = int'($urandom_range(30));
      h  = int'($urandom_range(30));
      dx = ($urandom_range(3) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(330));
      dy = ($urandom_range(3) == 0) ? int'($urandom_range(511))  : int'($urandom_range(250));
      rs = 0;
      if ($urandom_range(1) == 1) rs = int'($urandom_range(2, (w * h == 0) ? 1 : w * h + 2));
      if (rs == 1) rs = 0;
      fill(w * h, 12);
      blit(dx, dy, w, h, rs, 0, nwr);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
